// File: rtl/mem_stage_hs.sv
// MEM stage: holds one EX result/load, waits for the memory response, aligns loaded data for WB.
// Latency: ALU ops 1 cycle. Loads finish on the response cycle, or one cycle later with MS_RDATA_BUF_EN.
// Backpressure: ms_allowin follows ws_allowin in DONE. Without MS_RDATA_BUF_EN, WB stall also stalls data_rready.
module mem_stage_hs #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            es_valid,
    output logic            ms_allowin,
    input  logic [31:0]     es_pc,
    input  logic [4:0]      es_dest,
    input  logic            es_reg_we,
    input  logic            es_is_store,
    input  logic [2:0]      es_load_op,
    input  logic [XLEN-1:0] es_result,
    input  logic            data_rvalid,
    output logic            data_rready,
    input  logic [XLEN-1:0] data_rdata,
    output logic            ms_valid,
    input  logic            ws_allowin,
    output logic [31:0]     ms_pc,
    output logic [4:0]      ms_dest,
    output logic            ms_reg_we,
    output logic [XLEN-1:0] ms_result,
    output logic            fwd_we,
    output logic [4:0]      fwd_dest,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_data_ok,
    output logic            ms_timeout
);
    localparam int OFFW = $clog2(XLEN / 8);
    localparam int CNTW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {EMPTY, WAIT, DONE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [31:0]       pc_q;
    logic [4:0]        dest_q;
    logic              we_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   res_q;
    logic [CNTW-1:0]   cnt_q;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   ld_val;
    logic              accept, is_mem, tmo, resp;

    assign ms_allowin = (state == EMPTY) | ((state == DONE) & ws_allowin);
    // Flush kills the incoming op too, so an accept never lands in a flush cycle.
    assign accept     = es_valid & ms_allowin & ~flush;
    assign is_mem     = (es_load_op != 3'd0) | es_is_store;
    assign tmo        = ((state == WAIT) | (state == DRAIN)) & (cnt_q == CNTW'(MAX_WAIT));
    assign resp       = data_rvalid & data_rready;

    assign shifted = data_rdata >> {res_q[OFFW-1:0], 3'b000};

    always_comb begin
        case (op_q)
            3'd1:    ld_val = XLEN'($signed(shifted[7:0]));
            3'd2:    ld_val = XLEN'(shifted[7:0]);
            3'd3:    ld_val = XLEN'($signed(shifted[15:0]));
            3'd4:    ld_val = XLEN'(shifted[15:0]);
            3'd5:    ld_val = XLEN'($signed(shifted[31:0]));
            3'd6:    ld_val = XLEN'(shifted[31:0]);
            default: ld_val = shifted;
        endcase
    end

    always_comb begin
        ms_valid    = (state == DONE);
        data_rready = 1'b0;
        ms_result   = res_q;
        case (state)
            WAIT: begin
`ifdef MS_RDATA_BUF_EN
                data_rready = ~tmo;
`else
                data_rready = ws_allowin & ~tmo;
                ms_valid    = data_rvalid & ws_allowin & ~tmo;
                if ((op_q != 3'd0) && data_rvalid)
                    ms_result = ld_val;
`endif
            end
            DRAIN:   data_rready = ~tmo;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept)
                    state_nxt = is_mem ? WAIT : DONE;
            end
            WAIT: begin
                if (flush)
                    state_nxt = DRAIN;
                else if (tmo)
                    state_nxt = EMPTY;
                else if (resp)
`ifdef MS_RDATA_BUF_EN
                    state_nxt = DONE;
`else
                    state_nxt = EMPTY;
`endif
            end
            DONE: begin
                if (flush)
                    state_nxt = EMPTY;
                else if (ws_allowin)
                    state_nxt = accept ? (is_mem ? WAIT : DONE) : EMPTY;
            end
            DRAIN: begin
                if (tmo || resp)
                    state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt_q <= '0;
            else if ((state == WAIT) || (state == DRAIN))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= '0;
            dest_q <= '0;
            we_q   <= 1'b0;
            op_q   <= '0;
            res_q  <= '0;
        end else if (accept) begin
            pc_q   <= es_pc;
            dest_q <= es_dest;
            we_q   <= es_reg_we;
            op_q   <= es_load_op;
            res_q  <= es_result;
        end
`ifdef MS_RDATA_BUF_EN
        else if ((state == WAIT) && resp && !flush && (op_q != 3'd0)) begin
            res_q  <= ld_val;
        end
`endif
    end

    assign ms_pc       = pc_q;
    assign ms_dest     = dest_q;
    assign ms_reg_we   = we_q;
    assign ms_timeout  = tmo & ~(flush & (state == WAIT));
    assign fwd_we      = ((state == WAIT) | (state == DONE)) & we_q;
    assign fwd_dest    = dest_q;
    assign fwd_data    = ms_result;
    assign fwd_data_ok = (state == DONE);
endmodule
